// File: rtl/stall_ctrl_if.sv
// Hazard/stall controller bus: ID/EX/MEM hazard inputs and the stall/busy outputs.
// The pipeline drives through the master modport; stall_ctrl attaches to slave.
interface stall_ctrl_if;
    logic [4:0]  D_Rs;
    logic [4:0]  D_Rt;
    logic [1:0]  D_Tuse_Rs;
    logic [1:0]  D_Tuse_Rt;
    logic        D_Is_MD;
    logic [4:0]  E_Wreg;
    logic [1:0]  E_Tnew;
    logic [4:0]  M_Wreg;
    logic [1:0]  M_Tnew;
    logic        E_Mult_Start;
    logic        E_Div_Start;
    logic        PC_En;
    logic        FD_En;
    logic        DE_Clr;
    logic        MD_Busy;
    logic [31:0] Stall_Cnt;

    modport master (
        output D_Rs, D_Rt, D_Tuse_Rs, D_Tuse_Rt, D_Is_MD,
        output E_Wreg, E_Tnew, M_Wreg, M_Tnew, E_Mult_Start, E_Div_Start,
        input  PC_En, FD_En, DE_Clr, MD_Busy, Stall_Cnt
    );

    modport slave (
        input  D_Rs, D_Rt, D_Tuse_Rs, D_Tuse_Rt, D_Is_MD,
        input  E_Wreg, E_Tnew, M_Wreg, M_Tnew, E_Mult_Start, E_Div_Start,
        output PC_En, FD_En, DE_Clr, MD_Busy, Stall_Cnt
    );
endinterface

// File: rtl/stall_ctrl.sv
// Pipeline hazard/stall controller for the 5-stage MIPS core: Tuse/Tnew data
// hazards, mult/div busy tracking and a saturating count of stalled cycles.
module stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic         Clock,
    input  logic         Reset,
    stall_ctrl_if.slave  bus
);

    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_stall_cnt;

    logic             w_md_busy;
    logic             w_stall_rs;
    logic             w_stall_rt;
    logic             w_stall_md;
    logic             w_stall;

    assign w_md_busy = (r_cnt != '0);

    // NOTE: every variable written in always_comb is given a default first so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        w_stall_rs = 1'b0;
        w_stall_rt = 1'b0;
        w_stall_md = 1'b0;

        if (bus.D_Rs != 5'd0) begin
            w_stall_rs = ((bus.D_Rs == bus.E_Wreg) && (bus.D_Tuse_Rs < bus.E_Tnew)) ||
                         ((bus.D_Rs == bus.M_Wreg) && (bus.D_Tuse_Rs < bus.M_Tnew));
        end

        if (bus.D_Rt != 5'd0) begin
            w_stall_rt = ((bus.D_Rt == bus.E_Wreg) && (bus.D_Tuse_Rt < bus.E_Tnew)) ||
                         ((bus.D_Rt == bus.M_Wreg) && (bus.D_Tuse_Rt < bus.M_Tnew));
        end

        // The start cycle itself must stall too: the counter only loads on that edge.
        w_stall_md = bus.D_Is_MD && (bus.E_Mult_Start || bus.E_Div_Start || w_md_busy);
    end

    assign w_stall = w_stall_rs | w_stall_rt | w_stall_md;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_cnt <= '0;
        end else if (bus.E_Div_Start) begin
            r_cnt <= CNT_W'(DIV_CYCLES);
        end else if (bus.E_Mult_Start) begin
            r_cnt <= CNT_W'(MULT_CYCLES);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_stall_cnt <= 32'd0;
        end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign bus.PC_En     = ~w_stall;
    assign bus.FD_En     = ~w_stall;
    assign bus.DE_Clr    = w_stall;
    assign bus.MD_Busy   = w_md_busy;
    assign bus.Stall_Cnt = r_stall_cnt;

endmodule
